// File: rtl/chan_mux_reg_pkg.sv
// Shared definitions for chan_mux_reg: arbitration mode codes and select-width helper.
package chan_mux_defs;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // Width of a channel index; never less than one bit so sel/out_ch always exist.
  function automatic int chan_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chan_mux_reg_if.sv
// Producer/consumer bundle for chan_mux_reg; define PARITY_EN to add out_parity.
interface chan_mux_reg_if
  import chan_mux_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int CW    = chan_clog2(N)
);

  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [CW-1:0]      sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_ch;
`ifdef PARITY_EN
  logic               out_parity;

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_parity
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_parity
  );
`else
  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
`endif

endinterface

// File: rtl/chan_mux_reg_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] idx,
  output logic          any
);

  logic [CW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = CW'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/chan_mux_reg.sv
// N-channel registered mux (explicit select or round-robin) behind a valid/ready output.
// Define PARITY_EN to register an even-parity bit alongside out_data.
module chan_mux_reg
  import chan_mux_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = MODE_RR
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_reg_if.slave bus
);

  localparam int CW = chan_clog2(N);

  logic [N-1:0]     grant_oh;
  logic [CW-1:0]    grant_idx;
  logic             grant_any;
  logic [CW-1:0]    rr_ptr;
  logic             space;
  logic             load;
  logic [WIDTH-1:0] sel_data;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    out_ch_q;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(
        .N  (N),
        .CW (CW)
      ) u_arb (
        .req   (bus.in_valid),
        .ptr   (rr_ptr),
        .grant (grant_oh),
        .idx   (grant_idx),
        .any   (grant_any)
      );
    end else begin : g_sel
      // A select value beyond the last channel grants nothing.
      always_comb begin
        grant_oh  = '0;
        grant_idx = bus.sel;
        grant_any = 1'b0;
        if ((int'(bus.sel) < N) && bus.in_valid[bus.sel]) begin
          grant_any         = 1'b1;
          grant_oh[bus.sel] = 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == CW'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // The register can take new data when empty or being drained this same cycle.
  assign space        = ~out_valid_q | bus.out_ready;
  assign load         = space & grant_any;
  assign bus.in_ready = {N{load}} & grant_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_ch_q    <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if ((MODE == MODE_RR) && load) begin
      rr_ptr <= (grant_idx == CW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

`ifdef PARITY_EN
  logic out_parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity_q <= 1'b0;
    end else if (load) begin
      out_parity_q <= ^sel_data;
    end
  end

  assign bus.out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_chan_mux_reg.sv
// Bench for chan_mux_reg: round-robin N=4, select N=4 and select N=3 instances vs a reference model.
module tb_chan_mux_reg;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    int         ch;
    int         ptr;
  } mdl_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  mdl_t m_rr, m_sel, m_sel3;

  chan_mux_reg_if #(.WIDTH(8), .N(4)) rr_bus ();
  chan_mux_reg_if #(.WIDTH(8), .N(4)) sel_bus ();
  chan_mux_reg_if #(.WIDTH(8), .N(3)) sel3_bus ();

  chan_mux_reg #(.WIDTH(8), .N(4), .MODE(1)) u_rr   (.clk(clk), .rst_n(rst_n), .bus(rr_bus));
  chan_mux_reg #(.WIDTH(8), .N(4), .MODE(0)) u_sel  (.clk(clk), .rst_n(rst_n), .bus(sel_bus));
  chan_mux_reg #(.WIDTH(8), .N(3), .MODE(0)) u_sel3 (.clk(clk), .rst_n(rst_n), .bus(sel3_bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel that wins under the given mode, or -1 when nobody is eligible.
  function automatic int pickChannel(input int mode, input int n, input int ptr,
                                     input logic [31:0] v, input int s);
    if (mode == 0) return ((s < n) && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic mdl_t modelStep(input mdl_t m, input int mode, input int n,
                                     input logic [31:0] v, input logic [31:0] d,
                                     input int s, input logic ordy);
    mdl_t r;
    int   g;
    r = m;
    g = pickChannel(mode, n, m.ptr, v, s);
    if ((!m.vld || ordy) && g >= 0) begin
      r.vld  = 1'b1;
      r.data = d[g*8 +: 8];
      r.ch   = g;
      if (mode == 1) r.ptr = (g + 1) % n;
    end else if (ordy) begin
      r.vld = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] expReady(input int mode, input int n, input mdl_t m,
                                           input logic [31:0] v, input int s, input logic ordy);
    int g;
    g = pickChannel(mode, n, m.ptr, v, s);
    if ((!m.vld || ordy) && g >= 0) return 32'(1) << g;
    return 32'(0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr   = '{vld: 1'b0, data: 8'h00, ch: 0, ptr: 0};
      m_sel  = '{vld: 1'b0, data: 8'h00, ch: 0, ptr: 0};
      m_sel3 = '{vld: 1'b0, data: 8'h00, ch: 0, ptr: 0};
    end else begin
      m_rr   = modelStep(m_rr, 1, 4, 32'(rr_bus.in_valid), 32'(rr_bus.in_data),
                         int'(rr_bus.sel), rr_bus.out_ready);
      m_sel  = modelStep(m_sel, 0, 4, 32'(sel_bus.in_valid), 32'(sel_bus.in_data),
                         int'(sel_bus.sel), sel_bus.out_ready);
      m_sel3 = modelStep(m_sel3, 0, 3, 32'(sel3_bus.in_valid), 32'(sel3_bus.in_data),
                         int'(sel3_bus.sel), sel3_bus.out_ready);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkDut(input string nm, input int mode, input int n, input mdl_t m,
                          input logic [31:0] v, input int s, input logic ordy,
                          input logic ovld, input logic [7:0] odata,
                          input logic [31:0] och, input logic [31:0] irdy);
    checkOutput({nm, "_valid"}, 32'(ovld), 32'(m.vld));
    checkOutput({nm, "_data"}, 32'(odata), 32'(m.data));
    checkOutput({nm, "_ch"}, och, 32'(m.ch));
    checkOutput({nm, "_in_ready"}, irdy, expReady(mode, n, m, v, s, ordy));
  endtask

  task automatic checkAll();
    checkDut("rr", 1, 4, m_rr, 32'(rr_bus.in_valid), int'(rr_bus.sel), rr_bus.out_ready,
             rr_bus.out_valid, rr_bus.out_data, 32'(rr_bus.out_ch), 32'(rr_bus.in_ready));
    checkDut("sel", 0, 4, m_sel, 32'(sel_bus.in_valid), int'(sel_bus.sel), sel_bus.out_ready,
             sel_bus.out_valid, sel_bus.out_data, 32'(sel_bus.out_ch), 32'(sel_bus.in_ready));
    checkDut("sel3", 0, 3, m_sel3, 32'(sel3_bus.in_valid), int'(sel3_bus.sel),
             sel3_bus.out_ready, sel3_bus.out_valid, sel3_bus.out_data,
             32'(sel3_bus.out_ch), 32'(sel3_bus.in_ready));
`ifdef PARITY_EN
    checkOutput("rr_parity", 32'(rr_bus.out_parity), 32'(^m_rr.data));
    checkOutput("sel_parity", 32'(sel_bus.out_parity), 32'(^m_sel.data));
    checkOutput("sel3_parity", 32'(sel3_bus.out_parity), 32'(^m_sel3.data));
`endif
  endtask

  task automatic clearInputs();
    rr_bus.in_valid   = '0;  rr_bus.in_data   = '0;  rr_bus.sel   = '0;  rr_bus.out_ready   = 1'b1;
    sel_bus.in_valid  = '0;  sel_bus.in_data  = '0;  sel_bus.sel  = '0;  sel_bus.out_ready  = 1'b1;
    sel3_bus.in_valid = '0;  sel3_bus.in_data = '0;  sel3_bus.sel = '0;  sel3_bus.out_ready = 1'b1;
  endtask

  task automatic applyStimulus();
    rr_bus.in_valid    = 4'($urandom);
    rr_bus.in_data     = 32'($urandom);
    rr_bus.out_ready   = ($urandom_range(0, 3) != 0);
    sel_bus.in_valid   = 4'($urandom);
    sel_bus.in_data    = 32'($urandom);
    sel_bus.sel        = 2'($urandom_range(0, 3));
    sel_bus.out_ready  = ($urandom_range(0, 3) != 0);
    sel3_bus.in_valid  = 3'($urandom);
    sel3_bus.in_data   = 24'($urandom);
    sel3_bus.sel       = 2'($urandom_range(0, 3));
    sel3_bus.out_ready = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    checkOutput("reset_valid", 32'(rr_bus.out_valid), 32'(0));
    checkOutput("reset_data", 32'(rr_bus.out_data), 32'(0));
    checkOutput("reset_ch", 32'(rr_bus.out_ch), 32'(0));
    checkAll();
    rst_n = 1'b1;

    // Round-robin order with every channel requesting continuously.
    rr_bus.in_valid  = 4'hF;
    rr_bus.in_data   = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("rr_order_ch", 32'(rr_bus.out_ch), 32'(k % 4));
      checkOutput("rr_order_valid", 32'(rr_bus.out_valid), 32'(1));
      checkAll();
    end

    // Back-pressure holds the register; then drain.
    rr_bus.in_valid = 4'h0;
    @(negedge clk);
    checkOutput("drain_valid", 32'(rr_bus.out_valid), 32'(0));
    rr_bus.in_valid  = 4'b0100;
    rr_bus.in_data   = 32'h00A50000;
    rr_bus.out_ready = 1'b0;
    #1 checkOutput("hold_ready_pre", 32'(rr_bus.in_ready), 32'(4'b0100));
    @(negedge clk);
    checkOutput("hold_data", 32'(rr_bus.out_data), 32'(8'hA5));
    checkOutput("hold_ready", 32'(rr_bus.in_ready), 32'(0));
    checkAll();
    rr_bus.in_data = 32'h00FF0000;
    @(negedge clk);
    checkOutput("hold_stable", 32'(rr_bus.out_data), 32'(8'hA5));
    checkOutput("hold_valid", 32'(rr_bus.out_valid), 32'(1));
    checkAll();
    rr_bus.in_valid  = 4'h0;
    rr_bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_drained", 32'(rr_bus.out_valid), 32'(0));

    // Pointer at 3: ch0 wins, pointer 1; then only ch3 requests, wrap search, pointer 0.
    rr_bus.in_data  = 32'h40302010;
    rr_bus.in_valid = 4'b0001;
    @(negedge clk);
    checkOutput("wrap_ch0", 32'(rr_bus.out_ch), 32'(0));
    rr_bus.in_valid = 4'b1000;
    @(negedge clk);
    checkOutput("wrap_ch3", 32'(rr_bus.out_ch), 32'(3));
    checkOutput("wrap_data3", 32'(rr_bus.out_data), 32'(8'h40));
    rr_bus.in_valid = 4'hF;
    @(negedge clk);
    checkOutput("wrap_ptr0", 32'(rr_bus.out_ch), 32'(0));
    checkAll();
    clearInputs();

    // Explicit select, plus an out-of-range select on the 3-channel instance.
    sel_bus.sel        = 2'd1;
    sel_bus.in_valid   = 4'b0011;
    sel_bus.in_data    = 32'h00003C5A;
    sel3_bus.sel       = 2'd3;
    sel3_bus.in_valid  = 3'b111;
    sel3_bus.in_data   = 24'h778899;
    #1 checkOutput("sel_ready", 32'(sel_bus.in_ready), 32'(4'b0010));
    checkOutput("sel3_oor_ready", 32'(sel3_bus.in_ready), 32'(0));
    @(negedge clk);
    checkOutput("sel_data", 32'(sel_bus.out_data), 32'(8'h3C));
    checkOutput("sel_ch", 32'(sel_bus.out_ch), 32'(1));
    checkOutput("sel3_oor_valid", 32'(sel3_bus.out_valid), 32'(0));
    checkAll();
    clearInputs();

    // Asynchronous reset while holding data, then lowest channel wins after release.
    rr_bus.in_valid  = 4'b0001;
    rr_bus.in_data   = 32'h00000011;
    rr_bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("prereset_valid", 32'(rr_bus.out_valid), 32'(1));
    rst_n = 1'b0;
    #1 checkOutput("async_reset_valid", 32'(rr_bus.out_valid), 32'(0));
    checkOutput("async_reset_data", 32'(rr_bus.out_data), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rr_bus.in_valid  = 4'b1001;
    rr_bus.in_data   = 32'hCC0000AA;
    rr_bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ch", 32'(rr_bus.out_ch), 32'(0));
    checkOutput("post_reset_data", 32'(rr_bus.out_data), 32'(8'hAA));
    checkAll();

    // Parity loads: odd then even number of ones.
    rr_bus.in_valid = 4'b0001;
    rr_bus.in_data  = 32'h00000007;
    @(negedge clk);
    checkOutput("par_data07", 32'(rr_bus.out_data), 32'(8'h07));
`ifdef PARITY_EN
    checkOutput("par_07", 32'(rr_bus.out_parity), 32'(1));
`endif
    rr_bus.in_data = 32'h00000003;
    @(negedge clk);
    checkOutput("par_data03", 32'(rr_bus.out_data), 32'(8'h03));
`ifdef PARITY_EN
    checkOutput("par_03", 32'(rr_bus.out_parity), 32'(0));
`endif
    checkAll();

    repeat (400) begin
      applyStimulus();
      @(negedge clk);
      checkAll();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
